// File: rtl/fccc_ctrl_pkg.sv
// fccc_ctrl_pkg: FSM state type and counter-width helper shared by the lock/clken block
package fccc_ctrl_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, FILTER, RELEASE, RUN} state_e;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fccc_clken_div.sv
// fccc_clken_div: one channel clock-enable divider with loadable divisor
module fccc_clken_div #(
  parameter int DIV_W    = 8,
  parameter int DIV_INIT = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             rst_ch,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             clken
);
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d, last;
  logic rst_q, clken_q, clken_d;
  // rst_ch is the channel reset value for the coming cycle, so the strobe is decoded one edge early
  always_comb begin
    div_d   = load ? div : div_q;
    last    = (div_d == '0) ? '0 : div_d - 1'b1;
    cnt_d   = (rst_q || load || cnt_q >= last) ? '0 : cnt_q + 1'b1;
    clken_d = !rst_ch && (cnt_d == last);
  end
  // divisor, phase counter, local copy of channel reset and registered strobe
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      div_q   <= DIV_W'(DIV_INIT);
      cnt_q   <= '0;
      rst_q   <= 1'b1;
      clken_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_ch;
      clken_q <= clken_d;
    end
  assign clken = clken_q;
endmodule

// File: rtl/fccc_lock_clken_gen.sv
// fccc_lock_clken_gen: PLL lock qualification, staggered channel reset release and clock enables
module fccc_lock_clken_gen
  import fccc_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DIV_INIT    = 1,
  parameter int FILT_CYC    = 64,
  parameter int STAGGER_CYC = 16,
  parameter int LOSS_CNT_W  = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    PLL_LOCK,
  input  logic                    DIV_LOAD,
  input  logic [NUM_CH*DIV_W-1:0] DIV_VAL,
  output logic                    DIV_ACK,
  input  logic                    LOSS_CLR,
  output logic                    LOCKED,
  output logic [NUM_CH-1:0]       CH_RST,
  output logic [NUM_CH-1:0]       CH_CLKEN,
  output logic                    LOSS_STICKY,
  output logic [LOSS_CNT_W-1:0]   LOSS_CNT
);
  localparam int FW = cnt_w(FILT_CYC);
  localparam int SW = cnt_w(STAGGER_CYC * NUM_CH);
  state_e state_q, state_d;
  logic sync1_q, sync1_d, sync2_q, sync2_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic locked_q, locked_d, ack_q, ack_d, sticky_q, sticky_d, loss;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
  logic [LOSS_CNT_W-1:0] lcnt_q, lcnt_d;
  // synchroniser, FSM, filter/stagger counters and loss bookkeeping
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q  <= WAIT_LOCK;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      fcnt_q   <= '0;
      scnt_q   <= '0;
      locked_q <= 1'b0;
      ack_q    <= 1'b0;
      sticky_q <= 1'b0;
      ch_rst_q <= '1;
      lcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      fcnt_q   <= fcnt_d;
      scnt_q   <= scnt_d;
      locked_q <= locked_d;
      ack_q    <= ack_d;
      sticky_q <= sticky_d;
      ch_rst_q <= ch_rst_d;
      lcnt_q   <= lcnt_d;
    end
  // a low synchronised lock overrides every state; loss is only counted once the lock was qualified
  always_comb begin
    sync1_d  = PLL_LOCK;
    sync2_d  = sync1_q;
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    scnt_d   = scnt_q;
    locked_d = locked_q;
    ch_rst_d = ch_rst_q;
    ack_d    = DIV_LOAD;
    loss     = 1'b0;
    if (!sync2_q) begin
      state_d  = WAIT_LOCK;
      locked_d = 1'b0;
      ch_rst_d = '1;
      loss     = (state_q == RELEASE) || (state_q == RUN);
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          state_d = FILTER;
          fcnt_d  = '0;
        end
        FILTER:
          if (fcnt_q == FW'(FILT_CYC - 1)) begin
            state_d  = RELEASE;
            locked_d = 1'b1;
            scnt_d   = '0;
          end else fcnt_d = fcnt_q + 1'b1;
        RELEASE: begin
          scnt_d = scnt_q + 1'b1;
          for (int i = 0; i < NUM_CH; i++)
            if (scnt_q == SW'(STAGGER_CYC * (i + 1) - 1)) ch_rst_d[i] = 1'b0;
          if (scnt_q == SW'(STAGGER_CYC * NUM_CH - 1)) state_d = RUN;
        end
        default: ch_rst_d = '0;
      endcase
    end
    sticky_d = loss | (sticky_q & ~LOSS_CLR);
    lcnt_d   = loss ? lcnt_q + LOSS_CNT_W'(~&lcnt_q) : LOSS_CLR ? '0 : lcnt_q;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fccc_clken_div #(.DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) u_div (
      .CLK   (CLK),
      .RESET (RESET),
      .rst_ch(ch_rst_d[i]),
      .load  (DIV_LOAD),
      .div   (DIV_VAL[i*DIV_W +: DIV_W]),
      .clken (CH_CLKEN[i])
    );
  end
  assign LOCKED      = locked_q;
  assign CH_RST      = ch_rst_q;
  assign DIV_ACK     = ack_q;
  assign LOSS_STICKY = sticky_q;
  assign LOSS_CNT    = lcnt_q;
endmodule
